// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack DATA_MEM transaction per access (3 cycles + ack wait), Stall_o freezes the pipe while busy.
// Define MEM_TIMEOUT_EN to abort an unacked request after TIMEOUT_CYC REQ cycles and pulse BusErr_o.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ALUresult_i,
    input  logic [31:0] RS2data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  Funct3_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [31:0] MemData_o,
    output logic        Stall_o,
    output logic        Misalign_o,
    output logic        BusErr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        access;
    logic        is_store;
    logic        misaligned;
    logic        start;
    logic        timeout_hit;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // Access decode; a store with a load-only size code is treated as unsupported.
    always_comb begin
        access     = MemRead_i | MemWrite_i;
        is_store   = MemWrite_i;
        misaligned = 1'b0;
        case (Funct3_i)
            3'b000:  misaligned = 1'b0;
            3'b001:  misaligned = ALUresult_i[0];
            3'b010:  misaligned = |ALUresult_i[1:0];
            3'b100:  misaligned = is_store;
            3'b101:  misaligned = is_store | ALUresult_i[0];
            default: misaligned = 1'b1;
        endcase
    end

    assign start = (state == IDLE) && access && !misaligned;

    always_comb begin
        be_calc    = 4'b0000;
        wdata_calc = 32'h0;
        case (Funct3_i[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << ALUresult_i[1:0];
                wdata_calc = {4{RS2data_i[7:0]}};
            end
            2'b01: begin
                be_calc    = ALUresult_i[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{RS2data_i[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = RS2data_i;
            end
        endcase
        if (!is_store) begin
            wdata_calc = 32'h0;
        end
    end

    // Load alignment uses the size/lane captured at request time, not the live EX_MEM inputs.
    always_comb begin
        byte_sel  = dmem_rdata_i[{lane_q, 3'b000} +: 8];
        half_sel  = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_data = dmem_rdata_i;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (dmem_ack_i || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Stall_o    = 1'b0;
        Misalign_o = 1'b0;
        case (state)
            IDLE: begin
                Stall_o    = start;
                Misalign_o = access & misaligned;
            end
            REQ:     Stall_o = 1'b1;
            default: Stall_o = 1'b0;
        endcase
    end

    // Bus-side registers: loaded on request start, held stable for the whole REQ phase.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'h0;
            dmem_be_o    <= 4'b0000;
            dmem_wdata_o <= 32'h0;
            MemData_o    <= 32'h0;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= is_store;
                        dmem_addr_o  <= {ALUresult_i[31:2], 2'b00};
                        dmem_be_o    <= be_calc;
                        dmem_wdata_o <= wdata_calc;
                        funct3_q     <= Funct3_i;
                        lane_q       <= ALUresult_i[1:0];
                    end else if (access) begin
                        MemData_o <= 32'h0;
                    end
                end
                REQ: begin
                    if (dmem_ack_i) begin
                        dmem_req_o <= 1'b0;
                        MemData_o  <= dmem_we_o ? 32'h0 : load_data;
                    end else if (timeout_hit) begin
                        dmem_req_o <= 1'b0;
                        MemData_o  <= 32'h0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 9) ? $clog2(TIMEOUT_CYC + 1) : 9;

    logic [CNT_W-1:0] tmo_cnt;

    // An ack arriving in the limit cycle takes priority over the abort.
    assign timeout_hit = (state == REQ) && !dmem_ack_i && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmo_cnt  <= '0;
            BusErr_o <= 1'b0;
        end else begin
            BusErr_o <= timeout_hit;
            if (state != REQ) begin
                tmo_cnt <= '0;
            end else if (!dmem_ack_i) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign BusErr_o    = 1'b0;
`endif

endmodule
